// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a 16-entry byte FIFO.
// Back-to-back frames leave the line with no idle gap between them.
module uart_tx_fifo #(
   parameter int DELAY_FRAMES = 234,
   parameter int FIFO_AW      = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       txData,
   input  logic             txDataValid,
   output logic             txReady,
   output logic [FIFO_AW:0] fifoCount,
   output logic             txBusy,
   output logic             overflow,
   output logic             uart_tx
);

   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int CW    = (DELAY_FRAMES > 2) ? $clog2(DELAY_FRAMES) : 1;
   localparam logic [FIFO_AW:0] FULL = (FIFO_AW + 1)'(DEPTH);
   localparam logic [CW-1:0]    LAST = CW'(DELAY_FRAMES - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wrPtr;
   logic [FIFO_AW-1:0] rdPtr;
   logic [FIFO_AW:0]   countNext;
   logic               push;
   logic               pop;
   logic               notEmpty;

   state_t       state;
   state_t       stateNext;
   logic [CW-1:0] bitCnt;
   logic [CW-1:0] bitCntNext;
   logic [2:0]   bitIdx;
   logic [2:0]   bitIdxNext;
   logic [7:0]   shiftReg;
   logic [7:0]   shiftNext;
   logic         lineNext;
   logic         bitDone;

   assign push     = txDataValid & txReady;
   assign notEmpty = (fifoCount != '0);
   assign bitDone  = (bitCnt == LAST);

   // Occupancy after this edge; push and pop together leave it unchanged.
   always_comb begin
      countNext = fifoCount;
      unique case ({push, pop})
         2'b10:   countNext = fifoCount + 1'b1;
         2'b01:   countNext = fifoCount - 1'b1;
         default: countNext = fifoCount;
      endcase
   end

   // Storage array; pushes during reset are ignored.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem[wrPtr] <= txData;
      end
   end

   // FIFO pointers, count, registered ready and sticky overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         fifoCount <= '0;
         txReady   <= 1'b1;
         overflow  <= 1'b0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (pop) begin
            rdPtr <= rdPtr + 1'b1;
         end
         fifoCount <= countNext;
         txReady   <= (countNext != FULL);
         if (txDataValid && !txReady) begin
            overflow <= 1'b1;
         end
      end
   end

   // Frame sequencer: next state, bit timing, pop and line level.
   always_comb begin
      stateNext  = state;
      bitCntNext = bitDone ? '0 : bitCnt + 1'b1;
      bitIdxNext = bitIdx;
      shiftNext  = shiftReg;
      pop        = 1'b0;
      lineNext   = 1'b1;
      unique case (state)
         IDLE: begin
            bitCntNext = '0;
            bitIdxNext = '0;
            if (notEmpty) begin
               pop       = 1'b1;
               shiftNext = mem[rdPtr];
               stateNext = START;
            end
         end
         START: begin
            lineNext = 1'b0;
            if (bitDone) begin
               bitIdxNext = '0;
               stateNext  = DATA;
            end
         end
         DATA: begin
            lineNext = shiftReg[bitIdx];
            if (bitDone) begin
               if (bitIdx == 3'd7) begin
                  stateNext = STOP;
               end else begin
                  bitIdxNext = bitIdx + 1'b1;
               end
            end
         end
         STOP: begin
            lineNext = 1'b1;
            if (bitDone) begin
               if (notEmpty) begin
                  pop       = 1'b1;
                  shiftNext = mem[rdPtr];
                  stateNext = START;
               end else begin
                  stateNext = IDLE;
               end
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Sequencer state plus line and busy registers, one cycle behind state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         bitCnt   <= '0;
         bitIdx   <= '0;
         shiftReg <= '0;
         uart_tx  <= 1'b1;
         txBusy   <= 1'b0;
      end else begin
         state    <= stateNext;
         bitCnt   <= bitCntNext;
         bitIdx   <= bitIdxNext;
         shiftReg <= shiftNext;
         uart_tx  <= lineNext;
         txBusy   <= (state != IDLE);
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: per-cycle vector table for single
// and paired frames, then hand-written overflow, reset and timing runs.
module tb_uart_tx_fifo;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       vld;
   logic [7:0] data;
   logic       txReady;
   logic [4:0] cnt;
   logic       busy;
   logic       ovf;
   logic       tx;

   logic       rst2;
   logic       vld2;
   logic [7:0] data2;
   logic       txReady2;
   logic [4:0] cnt2;
   logic       busy2;
   logic       ovf2;
   logic       tx2;

   always #5 clk = ~clk;

   uart_tx_fifo #(.DELAY_FRAMES(D), .FIFO_AW(4)) dut (
      .clk(clk), .rst(rst), .txData(data), .txDataValid(vld),
      .txReady(txReady), .fifoCount(cnt), .txBusy(busy),
      .overflow(ovf), .uart_tx(tx)
   );

   uart_tx_fifo #(.DELAY_FRAMES(234), .FIFO_AW(4)) dut2 (
      .clk(clk), .rst(rst2), .txData(data2), .txDataValid(vld2),
      .txReady(txReady2), .fifoCount(cnt2), .txBusy(busy2),
      .overflow(ovf2), .uart_tx(tx2)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vecs = 0;
   int errs = 0;

   typedef struct {
      logic       r;
      logic       v;
      logic [7:0] d;
      logic       eTx;
      logic       eBusy;
      logic       eRdy;
      logic [4:0] eCnt;
      logic       eOvf;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic r, logic v, logic [7:0] d, logic eTx,
                               logic eBusy, logic eRdy, logic [4:0] eCnt,
                               logic eOvf);
      vec_t t;
      t.r = r; t.v = v; t.d = d;
      t.eTx = eTx; t.eBusy = eBusy; t.eRdy = eRdy;
      t.eCnt = eCnt; t.eOvf = eOvf;
      return t;
   endfunction

   // bits[i] is the i-th line bit: start, d0..d7, stop.
   function automatic void addFrame(logic [9:0] bits, logic [4:0] c1,
                                    int n1, logic [4:0] c2);
      for (int k = 0; k < 10 * D; k++) begin
         tbl.push_back(mk(1'b0, 1'b0, 8'h00, bits[k / D], 1'b1, 1'b1,
                          (k < n1) ? c1 : c2, 1'b0));
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic doReset();
      rst = 1'b1;
      vld = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   logic [7:0] rxQ[$];
   int         rxT[$];
   logic       rxStop[$];

   task automatic clearRx();
      rxQ.delete();
      rxT.delete();
      rxStop.delete();
   endtask

   int         monT0;
   logic [7:0] monB;

   // Line receiver: samples each bit mid-cell, records byte and start cycle.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (tx === 1'b0) begin
            monT0 = cyc;
            repeat (2) @(posedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (D) @(posedge clk);
               #2;
               monB[i] = tx;
            end
            repeat (D) @(posedge clk);
            #2;
            rxQ.push_back(monB);
            rxT.push_back(monT0);
            rxStop.push_back(tx);
         end
      end
   end

   int   tN;
   int   lowCnt;
   int   busyCnt;
   int   guard;
   vec_t t;

   initial begin
      rst = 1'b1; vld = 1'b0; data = 8'h00;
      rst2 = 1'b1; vld2 = 1'b0; data2 = 8'h00;

      // Reset with a push offered, then 0x55 on the first free edge.
      tbl.push_back(mk(1'b1, 1'b1, 8'hEE, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0));
      addFrame(10'b1010101010, 5'd0, 0, 5'd0);
      tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0));
      // 0xA3 then 0x0F: second push coincides with the first pop.
      tbl.push_back(mk(1'b0, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0));
      addFrame(10'b1101000110, 5'd1, 39, 5'd0);
      addFrame(10'b1000011110, 5'd0, 0, 5'd0);
      tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0));

      tick();
      tick();

      for (int i = 0; i < tbl.size(); i++) begin
         t = tbl[i];
         rst = t.r;
         vld = t.v;
         data = t.d;
         tick();
         vecs++;
         if ({tx, busy, txReady, cnt, ovf} !==
             {t.eTx, t.eBusy, t.eRdy, t.eCnt, t.eOvf}) begin
            errs++;
            $display("FAIL vec[%0d]: got tx=%b busy=%b rdy=%b cnt=%0d ovf=%b expected tx=%b busy=%b rdy=%b cnt=%0d ovf=%b",
                     i, tx, busy, txReady, cnt, ovf,
                     t.eTx, t.eBusy, t.eRdy, t.eCnt, t.eOvf);
         end
      end
      vld = 1'b0;

      // 18 consecutive pushes: 17 accepted, last dropped.
      doReset();
      repeat (5) tick();
      clearRx();
      for (int i = 0; i < 18; i++) begin
         vld = 1'b1;
         data = 8'(i);
         tick();
         if (i == 0) tN = cyc;
      end
      vld = 1'b0;
      check("ovf_set", 32'(ovf), 32'd1);
      check("full_cnt", 32'(cnt), 32'd16);
      check("full_rdy", 32'(txReady), 32'd0);
      repeat (700) tick();
      check("ovf_sticky", 32'(ovf), 32'd1);
      check("drain_cnt", 32'(cnt), 32'd0);
      check("rx_count17", 32'(rxQ.size()), 32'd17);
      for (int j = 0; j < rxQ.size() && j < 17; j++) begin
         check($sformatf("rx_byte[%0d]", j), 32'(rxQ[j]), 32'(j));
         check($sformatf("rx_stop[%0d]", j), 32'(rxStop[j]), 32'd1);
         check($sformatf("rx_start[%0d]", j), 32'(rxT[j] - tN),
               32'(2 + 40 * j));
      end

      // Push into a full FIFO exactly on the edge that pops.
      doReset();
      repeat (5) tick();
      clearRx();
      check("ovf_cleared", 32'(ovf), 32'd0);
      for (int i = 0; i < 17; i++) begin
         vld = 1'b1;
         data = 8'(8'h20 + i);
         tick();
         if (i == 0) tN = cyc;
      end
      vld = 1'b0;
      check("fill_cnt", 32'(cnt), 32'd16);
      check("fill_ovf", 32'(ovf), 32'd0);
      repeat (24) tick();
      check("pre_pop_cnt", 32'(cnt), 32'd16);
      check("pre_pop_rdy", 32'(txReady), 32'd0);
      vld = 1'b1;
      data = 8'hEE;
      tick();
      vld = 1'b0;
      check("pop_edge_ovf", 32'(ovf), 32'd1);
      check("pop_edge_cnt", 32'(cnt), 32'd15);
      check("pop_edge_rdy", 32'(txReady), 32'd1);
      repeat (700) tick();
      check("rx2_count17", 32'(rxQ.size()), 32'd17);
      for (int j = 0; j < rxQ.size() && j < 17; j++) begin
         check($sformatf("rx2_byte[%0d]", j), 32'(rxQ[j]),
               32'(8'h20 + j));
      end

      // Reset during DATA bit 3 with five bytes still queued.
      doReset();
      repeat (5) tick();
      clearRx();
      for (int i = 0; i < 6; i++) begin
         vld = 1'b1;
         data = 8'(8'h40 + i);
         tick();
      end
      vld = 1'b0;
      repeat (13) tick();
      check("mid_cnt", 32'(cnt), 32'd5);
      check("mid_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_tx", 32'(tx), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_cnt", 32'(cnt), 32'd0);
      check("abort_rdy", 32'(txReady), 32'd1);
      repeat (80) tick();
      check("abort_frames", 32'(rxQ.size()), 32'd1);
      check("abort_idle", 32'(busy), 32'd0);
      clearRx();
      vld = 1'b1;
      data = 8'h81;
      tick();
      vld = 1'b0;
      repeat (50) tick();
      check("post_rx_count", 32'(rxQ.size()), 32'd1);
      if (rxQ.size() > 0) begin
         check("post_rx_byte", 32'(rxQ[0]), 32'h81);
         check("post_rx_stop", 32'(rxStop[0]), 32'd1);
      end

      // Full-rate timing: 0xFF gives a lone 234-clock start bit.
      rst2 = 1'b0;
      vld2 = 1'b1;
      data2 = 8'hFF;
      tick();
      vld2 = 1'b0;
      check("d234_n0_tx", 32'(tx2), 32'd1);
      tick();
      check("d234_n1_tx", 32'(tx2), 32'd1);
      tick();
      check("d234_n2_tx", 32'(tx2), 32'd0);
      lowCnt = 0;
      busyCnt = 0;
      guard = 0;
      while (busy2 === 1'b1 && guard < 3000) begin
         busyCnt++;
         if (tx2 === 1'b0) lowCnt++;
         guard++;
         tick();
      end
      check("d234_start_len", 32'(lowCnt), 32'd234);
      check("d234_frame_len", 32'(busyCnt), 32'd2340);
      check("d234_end_tx", 32'(tx2), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DELAY_FRAMES, default 234: clocks per UART bit (27 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_AW, default 4: FIFO address width; depth = 2**FIFO_AW = 16 entries.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port txData, input, 8 bits: byte offered for transmission.
REQ-006 SHALL have port txDataValid, input, 1 bit: push request, qualified by txReady.
REQ-007 SHALL have port txReady, output, 1 bit: high when the FIFO is not full; registered.
REQ-008 SHALL have port fifoCount, output, FIFO_AW+1 bits: number of queued bytes, 0..16.
REQ-009 SHALL have port txBusy, output, 1 bit: high while a frame is on the line (state != IDLE).
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag, set when a push is rejected.
REQ-011 SHALL have port uart_tx, output, 1 bit: serial line, 8N1, idle high; registered.

Function
REQ-012 A push SHALL occur on a clk edge where txDataValid=1 and txReady=1; txData is written at wrPtr, and wrPtr increments modulo 16.
REQ-013 A push attempted while txReady=0 SHALL be dropped and SHALL set overflow=1; FIFO contents and pointers SHALL stay unchanged.
REQ-014 Pointers SHALL wrap modulo depth; full means fifoCount==16 and empty means fifoCount==0; txReady SHALL equal (fifoCount != 16).
REQ-015 On a simultaneous push and pop, both SHALL take effect in the same cycle and fifoCount SHALL be unchanged.
REQ-016 When full, txReady SHALL stay 0 even if a pop occurs on the same edge; the push is rejected and overflow is set.
REQ-017 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-018 Bit timing SHALL use a bit counter that counts 0..DELAY_FRAMES-1; each state or data bit lasts exactly DELAY_FRAMES clocks.
REQ-019 IDLE: uart_tx=1; if fifoCount != 0, the FSM SHALL pop the byte at rdPtr into a shift register, increment rdPtr, and go to START.
REQ-020 START: uart_tx=0 for one bit time, then the FSM SHALL go to DATA with bit index 0.
REQ-021 DATA: uart_tx SHALL carry shift-register bit[index], LSB first; after index 7 completes, the FSM SHALL go to STOP.
REQ-022 STOP: uart_tx=1 for one bit time; at its end the FSM SHALL pop and go directly to START if the FIFO is non-empty (no idle gap), otherwise go to IDLE.
REQ-023 Latency: a push at edge N into an empty FIFO with the FSM in IDLE SHALL produce the pop at edge N+1; uart_tx SHALL go low starting from edge N+2.
REQ-024 One frame SHALL be exactly 10*DELAY_FRAMES clocks; back-to-back frames SHALL be contiguous.
REQ-025 A byte popped into the shift register SHALL be unaffected by later pushes, including pushes into the same FIFO slot after wrap-around.
REQ-026 txBusy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.

Reset
REQ-027 While rst=1 at an edge, the block SHALL set: state=IDLE, uart_tx=1, txBusy=0, txReady=1, fifoCount=0, overflow=0, pointers=0, bit counter=0.
REQ-028 A reset asserted mid-frame SHALL abort the frame immediately: uart_tx=1 after that edge, and queued bytes SHALL be discarded.
REQ-029 Pushes presented while rst=1 SHALL be ignored.
REQ-030 The first push SHALL be accepted on the first edge with rst=0.

Verification (DELAY_FRAMES=4 unless stated)
REQ-031 The bench SHALL push 0x55 once into an idle block -> uart_tx low from edge N+2, then the sequence 0,1,0,1,0,1,0,1,0,1 plus stop=1, each bit 4 clocks (40 clocks total); txBusy=1 throughout; fifoCount returns to 0.
REQ-032 The bench SHALL push 0xA3 and 0x0F on consecutive cycles -> two contiguous 40-clock frames, data LSB first 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0, with no idle high between the stop bit and the second start bit.
REQ-033 The bench SHALL push 18 bytes 0x00..0x11 on consecutive cycles -> 17 accepted (one already popped plus 16 queued) and 0x11 dropped; overflow=1 and stays 1 until reset; transmitted order is 0x00..0x10.
REQ-034 With the FIFO full, the bench SHALL push at the edge where STOP ends and a pop occurs -> push rejected, overflow=1, fifoCount goes 16->15.
REQ-035 The bench SHALL assert rst for 1 cycle during DATA bit 3 with 5 bytes queued -> uart_tx=1, txBusy=0, fifoCount=0 after that edge; no further frames are sent; a new push of 0x81 then transmits correctly.
REQ-036 With DELAY_FRAMES=234, the bench SHALL send one byte -> frame length exactly 2340 clocks, measured from uart_tx falling edge to end of stop bit.
